// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder
//   Multi-digit packed-BCD adder that processes one decimal digit per clock, least
//   significant digit first. Each digit uses the single-digit BCD rule: a binary sum
//   above 9 is corrected by +6 and produces a decimal carry into the next digit.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  operation request, sampled only in idle or done
//   a, b   packed BCD operands, digit i = [4i+3:4i], digit 0 = LSD
//   cin    decimal carry into digit 0
//   busy   high while digits are being added
//   done   one-cycle pulse; sum/cout/err are valid
//   sum    packed BCD result (registered, held until next accept)
//   cout   decimal carry out of the most significant digit
//   err    sticky flag: a processed digit of a or b was above 9
module bcd_serial_adder #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            cout_q, cout_d;
    logic            err_q, err_d;

    // Current digit pair and its BCD sum
    logic [3:0] a_dig, b_dig, digit;
    logic [4:0] bin_sum;
    logic       dig_carry;

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IdxW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
        bin_sum   = {1'b0, a_dig} + {1'b0, b_dig} + {4'b0000, carry_q};
        dig_carry = (bin_sum > 5'd9);
        // Low nibble of (t + 6); invalid input digits still follow this rule
        digit     = dig_carry ? (bin_sum[3:0] + 4'd6) : bin_sum[3:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = StAdd;
                end else if (state_q == StDone) begin
                    state_d = StIdle;
                end
            end
            StAdd: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (idx_q == IdxW'(i)) begin
                        sum_d[4*i +: 4] = digit;
                    end
                end
                carry_d = dig_carry;
                err_d   = err_q | (a_dig > 4'd9) | (b_dig > 4'd9);
                if (idx_q == LastIdx) begin
                    // Wrap so the counter never exceeds DIGITS-1
                    idx_d   = '0;
                    cout_d  = dig_carry;
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            err_q   <= err_d;
        end
    end

    assign busy = (state_q == StAdd);
    assign done = (state_q == StDone);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign err  = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy, done, cout, err;
    logic [W-1:0] sum;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .err  (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One operation from idle: checks busy/done on each of the 5 cycles after the
    // accept edge, the result in the done cycle, and that it holds afterwards.
    task automatic run_op(input string name, input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic [15:0] es, input logic ec,
                          input logic ee);
        logic timing_ok;
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        cin   = ~vc;
        timing_ok = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (busy !== 1'(k <= 4) || done !== 1'(k == 5)) timing_ok = 1'b0;
        end
        check({name, "_timing"}, {31'd0, timing_ok}, 32'd1);
        check({name, "_sum"}, {16'd0, sum}, {16'd0, es});
        check({name, "_cout_err"}, {30'd0, cout, err}, {30'd0, ec, ee});
        @(negedge clk);
        check({name, "_hold"}, {12'd0, done, busy, sum, cout, err},
              {12'd0, 2'b00, es, ec, ee});
    endtask

    vec_t vecs[10];
    logic timing_ok;
    int   n_done, d1, d2;
    logic [15:0] s1, s2;
    logic bad;

    initial begin
        vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[3] = '{16'h0008, 16'h0003, 1'b0, 16'h0011, 1'b0, 1'b0};
        vecs[4] = '{16'h0009, 16'h0008, 1'b0, 16'h0017, 1'b0, 1'b0};
        vecs[5] = '{16'h0004, 16'h0004, 1'b0, 16'h0008, 1'b0, 1'b0};
        vecs[6] = '{16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1};
        vecs[7] = '{16'h0050, 16'h0050, 1'b1, 16'h0101, 1'b0, 1'b0};
        vecs[8] = '{16'hF000, 16'h0000, 1'b0, 16'h5000, 1'b1, 1'b1};
        vecs[9] = '{16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset state, during and just after reset
        repeat (2) @(negedge clk);
        check("reset_during", {27'd0, busy, done, cout, err, |sum}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_after", {27'd0, busy, done, cout, err, |sum}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].sum, vecs[i].cout, vecs[i].err);
        end

        // start pulsed during ADD must be ignored
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        timing_ok = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (busy !== 1'(k <= 4) || done !== 1'(k == 5)) timing_ok = 1'b0;
            if (k == 2) begin
                start = 1'b1; a = 16'h9999; b = 16'h9999; cin = 1'b1;
            end
            if (k == 3) start = 1'b0;
        end
        check("ign_timing", {31'd0, timing_ok}, 32'd1);
        check("ign_sum", {15'd0, cout, sum}, {15'd0, 1'b0, 16'h6912});
        @(negedge clk);
        check("ign_no_queue", {30'd0, busy, done}, 32'd0);

        // start held high: back-to-back ops accepted from done
        @(negedge clk);
        start = 1'b1; a = 16'h1234; b = 16'h5678; cin = 1'b0;
        @(posedge clk);
        #1 a = 16'h0008; b = 16'h0003;
        n_done = 0; d1 = 0; d2 = 0; s1 = '0; s2 = '0; bad = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy === 1'b1 && done === 1'b1) bad = 1'b1;
            if (done === 1'b1) begin
                n_done++;
                if (n_done == 1) begin d1 = k; s1 = sum; end
                if (n_done == 2) begin d2 = k; s2 = sum; end
            end
            if (k == 6) start = 1'b0;
        end
        check("b2b_count", n_done, 2);
        check("b2b_first_cycle", d1, 5);
        check("b2b_period", d2 - d1, 5);
        check("b2b_sum1", {16'd0, s1}, 32'h6912);
        check("b2b_sum2", {16'd0, s2}, 32'h0011);
        check("b2b_busy_done_excl", {31'd0, bad}, 32'd0);

        // Async reset during ADD after two digits
        @(negedge clk);
        start = 1'b1; a = 16'h000A; b = 16'h0000; cin = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_sum", {15'd0, busy, sum}, {15'd0, 1'b1, 16'h0010});
        check("rst_pre_err", {31'd0, err}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_immediate", {15'd0, busy, done, cout, err, sum[12:0]}, 32'd0);
        check("rst_immediate_sum", {16'd0, sum}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
        end
        check("rst_no_resume", {31'd0, bad}, 32'd0);
        run_op("post_rst", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
